// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter and its benches.
// Register offsets describe the accumulator/counter peripheral the arbiter usually fronts.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam int          MAX_NREQ = 4;
    localparam logic [3:0]  WE_FULL  = 4'hF;

    localparam logic [31:0] CLR = 32'h0;
    localparam logic [31:0] ADD = 32'h4;
    localparam logic [31:0] ACC = 32'h8;
    localparam logic [31:0] CNT = 32'hC;

    function automatic logic [1:0] oh_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~excl) searching from last+1, wrapping.
// Zero latency; o_vld low when nothing is eligible.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_last,
    input  logic [NREQ-1:0] i_excl,
    output logic [NREQ-1:0] o_pick,
    output logic            o_vld
);
    logic [NREQ-1:0] w_masked;

    assign w_masked = i_req & ~i_excl;

    always_comb begin
        o_pick = '0;
        o_vld  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!o_vld && (j == (int'(i_last) + k) % NREQ) && w_masked[j]) begin
                    o_pick[j] = 1'b1;
                    o_vld     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares one peripheral bus slave between NREQ requesters: round-robin, one beat per grant, optional lock.
// Define ARB_LOCK_TIMEOUT_EN to force a re-arbitration after LOCK_MAX consecutive locked beats.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [4*NREQ-1:0]   m_we,
    input  logic [32*NREQ-1:0]  m_addr,
    input  logic [32*NREQ-1:0]  m_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [31:0]         m_rdata,
    output logic                busy,
    output logic [1:0]          owner,
    output logic                p_ce,
    output logic [3:0]          p_we,
    output logic [31:0]         p_addr,
    output logic [31:0]         p_wdata,
    input  logic [31:0]         p_rdata
);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);
    localparam logic [1:0]      LAST_RST = 2'(NREQ - 1);

    arb_state_t      r_state, w_nxt_state;
    logic [NREQ-1:0] r_gnt, w_nxt_gnt;
    logic [NREQ-1:0] r_done, w_nxt_done;
    logic [31:0]     r_rdata, w_nxt_rdata;
    logic [1:0]      r_owner, w_nxt_owner;
    logic [1:0]      r_last, w_nxt_last;
    logic            r_ce, w_nxt_ce;
    logic [3:0]      r_we, w_nxt_we;
    logic [31:0]     r_addr, w_nxt_addr;
    logic [31:0]     r_wdata, w_nxt_wdata;

    logic [NREQ-1:0] w_own_oh, w_excl, w_pick;
    logic [1:0]      w_ptr, w_load_idx;
    logic            w_pick_vld, w_owner_lk, w_keep, w_load;

    assign w_own_oh   = ONE << r_owner;
    assign w_owner_lk = |(lock & req & w_own_oh);
    assign w_ptr      = (r_state == ST_RESP) ? r_owner : r_last;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] r_lock_cnt, w_nxt_lock_cnt;
    logic          w_tmo, w_others;

    assign w_others       = |(req & ~w_own_oh);
    assign w_tmo          = w_owner_lk && (r_lock_cnt == CW'(LOCK_MAX - 1));
    // On timeout the owner only keeps the bus if nobody else is asking.
    assign w_keep         = w_owner_lk && !(w_tmo && w_others);
    assign w_excl         = (r_state == ST_RESP && w_tmo) ? w_own_oh : '0;
    assign w_nxt_lock_cnt = (w_keep && !w_tmo) ? r_lock_cnt + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (!reset)                  r_lock_cnt <= '0;
        else if (r_state == ST_RESP) r_lock_cnt <= w_nxt_lock_cnt;
    end
`else
    localparam int unused_lock_max = LOCK_MAX;
    assign w_keep = w_owner_lk;
    assign w_excl = '0;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req  (req),
        .i_last (w_ptr),
        .i_excl (w_excl),
        .o_pick (w_pick),
        .o_vld  (w_pick_vld)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_done  = '0;
        w_nxt_rdata = r_rdata;
        w_nxt_owner = r_owner;
        w_nxt_last  = r_last;
        w_nxt_ce    = r_ce;
        w_nxt_we    = r_we;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_load      = 1'b0;
        w_load_idx  = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_load     = 1'b1;
                    w_load_idx = oh_to_idx(MAX_NREQ'(w_pick));
                end
            end
            ST_ACCESS: begin
                w_nxt_rdata = p_rdata;
                w_nxt_done  = r_gnt;
                w_nxt_gnt   = '0;
                w_nxt_ce    = 1'b0;
                w_nxt_state = ST_RESP;
            end
            ST_RESP: begin
                w_nxt_last = r_owner;
                if (w_keep) begin
                    w_load = 1'b1;
                end else if (w_pick_vld) begin
                    w_load     = 1'b1;
                    w_load_idx = oh_to_idx(MAX_NREQ'(w_pick));
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        if (w_load) begin
            w_nxt_state = ST_ACCESS;
            w_nxt_owner = w_load_idx;
            w_nxt_gnt   = ONE << w_load_idx;
            w_nxt_ce    = 1'b1;
            w_nxt_we    = m_we[4*w_load_idx +: 4];
            w_nxt_addr  = m_addr[32*w_load_idx +: 32];
            w_nxt_wdata = m_wdata[32*w_load_idx +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_nxt_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_ce    <= 1'b0;
            r_we    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_gnt   <= w_nxt_gnt;
            r_done  <= w_nxt_done;
            r_rdata <= w_nxt_rdata;
            r_owner <= w_nxt_owner;
            r_last  <= w_nxt_last;
            r_ce    <= w_nxt_ce;
            r_we    <= w_nxt_we;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign m_rdata = r_rdata;
    assign busy    = (r_state != ST_IDLE);
    assign owner   = r_owner;
    assign p_ce    = r_ce;
    assign p_we    = r_we;
    assign p_addr  = r_addr;
    assign p_wdata = r_wdata;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter with a behavioural accumulator/counter peripheral.
module tb_periph_bus_arbiter;
    import periph_arb_pkg::*;

    localparam int NREQ     = 2;
    localparam int LOCK_MAX = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, lock;
    logic [4*NREQ-1:0]   m_we;
    logic [32*NREQ-1:0]  m_addr, m_wdata;
    logic [NREQ-1:0]     gnt, done;
    logic [31:0]         m_rdata;
    logic                busy;
    logic [1:0]          owner;
    logic                p_ce;
    logic [3:0]          p_we;
    logic [31:0]         p_addr, p_wdata, p_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    periph_bus_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .gnt(gnt), .done(done), .m_rdata(m_rdata), .busy(busy), .owner(owner),
        .p_ce(p_ce), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata)
    );

    always #5 clk = ~clk;

    // Accumulator/counter peripheral: commits writes on the edge where p_ce is high.
    logic [31:0] pm_acc = '0;
    logic [31:0] pm_cnt = '0;
    always @(posedge clk) begin
        if (p_ce && p_we == WE_FULL) begin
            if (p_addr == CLR) begin
                pm_acc <= '0;
                pm_cnt <= '0;
            end else if (p_addr == ADD) begin
                pm_acc <= pm_acc + p_wdata;
                pm_cnt <= pm_cnt + 32'd1;
            end
        end
    end
    assign p_rdata = !p_ce ? 32'd0 : (p_addr == ACC) ? pm_acc : (p_addr == CNT) ? pm_cnt : 32'd0;

    logic [3:0]  lk_we   [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
    logic [31:0] lk_addr [4] = '{32'h0, 32'h4, 32'h4, 32'h8};
    logic [31:0] lk_wd   [4] = '{32'd0, 32'd3, 32'd4, 32'd0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        m_we[4*i +: 4]      = we;
        m_addr[32*i +: 32]  = addr;
        m_wdata[32*i +: 32] = wd;
    endtask

    // One isolated beat for requester i; returns to the caller in the done cycle.
    task automatic beat(input int i, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
        req    = '0;
        req[i] = 1'b1;
        set_m(i, we, addr, wd);
        tick();
        check_eq("bt_gnt",   32'(gnt), 32'(1 << i));
        check_eq("bt_ce",    32'(p_ce), 32'd1);
        check_eq("bt_addr",  p_addr, addr);
        check_eq("bt_we",    32'(p_we), 32'(we));
        check_eq("bt_wdata", p_wdata, wd);
        req = '0;
        tick();
        check_eq("bt_done",   32'(done), 32'(1 << i));
        check_eq("bt_ce_off", 32'(p_ce), 32'd0);
        rd = m_rdata;
    endtask

    initial begin
        logic [31:0] rd;

        // Reset with random inputs
        reset = 1'b0;
        lock  = '0;
        for (int c = 0; c < 2; c++) begin
            req     = 2'($urandom);
            lock    = 2'($urandom);
            m_we    = 8'($urandom);
            m_addr  = {$urandom, $urandom};
            m_wdata = {$urandom, $urandom};
            tick();
        end
        check_eq("rst_gnt",   32'(gnt), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_ce",    32'(p_ce), 32'd0);
        check_eq("rst_we",    32'(p_we), 32'd0);
        check_eq("rst_addr",  p_addr, 32'd0);
        check_eq("rst_wdata", p_wdata, 32'd0);

        // First grant after release goes to requester 0
        reset = 1'b1;
        lock  = '0;
        req   = 2'b11;
        set_m(0, 4'h0, CNT, 32'd0);
        set_m(1, 4'h0, CNT, 32'd0);
        tick();
        check_eq("first_gnt",  32'(gnt), 32'b01);
        check_eq("first_busy", 32'(busy), 32'd1);
        req = '0;
        tick();
        check_eq("first_done",  32'(done), 32'b01);
        check_eq("first_rdata", m_rdata, 32'd0);
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single write then read back
        beat(0, 4'hF, ADD, 32'd5, rd);
        tick();
        beat(0, 4'h0, ACC, 32'd0, rd);
        check_eq("rd_acc5", rd, 32'd5);
        beat(0, 4'h0, CNT, 32'd0, rd);
        check_eq("rd_cnt1", rd, 32'd1);

        // Two continuous unlocked requesters alternate
        beat(1, 4'hF, CLR, 32'd0, rd);
        tick();
        req = 2'b11;
        set_m(0, 4'hF, ADD, 32'd1);
        set_m(1, 4'hF, ADD, 32'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            check_eq("alt_gnt", 32'(gnt), (b % 2 == 0) ? 32'b01 : 32'b10);
            if (b == 3) req = '0;
            tick();
            check_eq("alt_done", 32'(done), (b % 2 == 0) ? 32'b01 : 32'b10);
        end
        check_eq("alt_owner", 32'(owner), 32'd1);
        tick();
        beat(1, 4'h0, ACC, 32'd0, rd);
        check_eq("alt_acc4", rd, 32'd4);
        tick();

        // Locked clear/add/add/read with requester 1 pending
        req  = 2'b11;
        lock = 2'b01;
        set_m(0, lk_we[0], lk_addr[0], lk_wd[0]);
        set_m(1, 4'h0, CNT, 32'd0);
        for (int s = 0; s < 4; s++) begin
            tick();
            check_eq("lk_gnt", 32'(gnt), 32'b01);
            if (s < 3) set_m(0, lk_we[s+1], lk_addr[s+1], lk_wd[s+1]);
            lock = (s < 3) ? 2'b01 : 2'b00;
            tick();
            check_eq("lk_done", 32'(done), 32'b01);
            check_eq("lk_gnt_off", 32'(gnt), 32'd0);
            if (s == 3) check_eq("lk_acc7", m_rdata, 32'd7);
        end
        req = 2'b10;
        tick();
        check_eq("lk_gnt1", 32'(gnt), 32'b10);
        req = '0;
        tick();
        check_eq("lk_done1", 32'(done), 32'b10);
        check_eq("lk_cnt2", m_rdata, 32'd2);
        tick();

        // Reset in the middle of ACCESS
        req = 2'b01;
        set_m(0, 4'hF, ADD, 32'd9);
        tick();
        check_eq("mid_gnt", 32'(gnt), 32'b01);
        reset = 1'b0;
        tick();
        check_eq("mid_ce",   32'(p_ce), 32'd0);
        check_eq("mid_done", 32'(done), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_gnt0", 32'(gnt), 32'd0);
        reset = 1'b1;
        req   = 2'b11;
        set_m(0, 4'h0, ACC, 32'd0);
        set_m(1, 4'h0, ACC, 32'd0);
        tick();
        check_eq("post_gnt", 32'(gnt), 32'b01);
        req = '0;
        tick();
        check_eq("post_done", 32'(done), 32'b01);
        tick();

        // Long lock with requester 1 pending
        req  = 2'b01;
        lock = 2'b01;
        set_m(0, 4'hF, ADD, 32'd1);
        set_m(1, 4'h0, CNT, 32'd0);
        tick();
        check_eq("lt_gnt_b1", 32'(gnt), 32'b01);
        req = 2'b11;
        tick();
        check_eq("lt_done_b1", 32'(done), 32'b01);
        for (int b = 1; b < 4; b++) begin
            tick();
            check_eq("lt_gnt", 32'(gnt), 32'b01);
            tick();
            check_eq("lt_done", 32'(done), 32'b01);
        end
`ifdef ARB_LOCK_TIMEOUT_EN
        tick();
        check_eq("lt_tmo_gnt1", 32'(gnt), 32'b10);
        req = 2'b01;
        tick();
        check_eq("lt_tmo_done1", 32'(done), 32'b10);
        tick();
        check_eq("lt_resume_gnt0", 32'(gnt), 32'b01);
        req  = '0;
        lock = '0;
        tick();
        check_eq("lt_resume_done0", 32'(done), 32'b01);
`else
        tick();
        check_eq("lt_hold_gnt0", 32'(gnt), 32'b01);
        lock = '0;
        req  = 2'b10;
        tick();
        check_eq("lt_hold_done0", 32'(done), 32'b01);
        tick();
        check_eq("lt_rel_gnt1", 32'(gnt), 32'b10);
        req = '0;
        tick();
        check_eq("lt_rel_done1", 32'(done), 32'b10);
`endif
        tick();
        check_eq("end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
